// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared definitions.
// Default geometry used by the FIFO and its storage array.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 4;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo storage: 1-write/1-read register array.
// Read data is registered and cleared by reset; the array is not.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int N_REGS     = 2**ADDR_BITS
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  w_en,
    input  logic [ADDR_BITS-1:0]  w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    input  logic [ADDR_BITS-1:0]  r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] fifo_mem_reg [0:N_REGS-1];

    // Write port: store the word at the write address.
    always_ff @(posedge clk_i) begin
        if (w_en) begin
            fifo_mem_reg[w_addr] <= w_data;
        end
    end

    // Read port: hold output unless a read is accepted.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= fifo_mem_reg[r_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags.
// Wrap-bit pointers give the full 2**ADDR_BITS capacity.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_en,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full
);

    localparam int N_REGS = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] PTR_ONE = (ADDR_BITS+1)'(1);

    logic [ADDR_BITS:0] w_ptr_r;
    logic [ADDR_BITS:0] r_ptr_r;
    logic               w_en_r;
    logic               r_en_r;

    // Flags come only from the pointer registers.
    assign fifo_empty = (w_ptr_r == r_ptr_r);
    assign fifo_full  =
        (w_ptr_r[ADDR_BITS-1:0] == r_ptr_r[ADDR_BITS-1:0]) &&
        (w_ptr_r[ADDR_BITS] != r_ptr_r[ADDR_BITS]);

    // Overflowing writes and underflowing reads are dropped here.
    assign w_en_r = w_en & ~fifo_full;
    assign r_en_r = r_en & ~fifo_empty;

    // Write pointer advances on each accepted write.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            w_ptr_r <= '0;
        end else if (w_en_r) begin
            w_ptr_r <= w_ptr_r + PTR_ONE;
        end
    end

    // Read pointer advances on each accepted read.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_ptr_r <= '0;
        end else if (r_en_r) begin
            r_ptr_r <= r_ptr_r + PTR_ONE;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .N_REGS     (N_REGS)
    ) u_mem (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .w_en     (w_en_r),
        .w_addr   (w_ptr_r[ADDR_BITS-1:0]),
        .w_data   (data_in),
        .r_en     (r_en_r),
        .r_addr   (r_ptr_r[ADDR_BITS-1:0]),
        .r_data   (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// sync_fifo bench: scenario tasks against a queue model.
// Inputs change 1ns after a rising edge; outputs are checked there.
module tb_sync_fifo;

    logic       clk_i = 1'b0;
    logic       resetn_i;
    logic [7:0] data_in;
    logic       w_en;
    logic       r_en;
    logic [7:0] data_out;
    logic       fifo_empty;
    logic       fifo_full;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    logic [7:0] exp_dout;

    sync_fifo #(.DATA_WIDTH(8), .ADDR_BITS(4)) dut (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .data_in    (data_in),
        .w_en       (w_en),
        .r_en       (r_en),
        .data_out   (data_out),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    always #5 clk_i = ~clk_i;

    // Advance the model with the driven inputs, then clock the DUT.
    task automatic tick();
        bit wa;
        bit ra;
        if (!resetn_i) begin
            q.delete();
            exp_dout = 8'h00;
        end else begin
            ra = r_en && (q.size() != 0);
            wa = w_en && (q.size() < 16);
            if (ra) exp_dout = q.pop_front();
            if (wa) q.push_back(data_in);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        resetn_i = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        data_in = 8'h00;
        tick();
        tick();
        resetn_i = 1'b1;
        tick();
        total++;
        if (fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_empty got=%b want=1", fifo_empty);
        end
        total++;
        if (fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_full got=%b want=0", fifo_full);
        end
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_dout got=%h want=00", data_out);
        end
        r_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (data_out !== 8'h00 || dut.r_ptr_r !== 5'd0) begin
                bad++;
                $display("FAIL underflow dout=%h rptr=%0d want 00/0",
                         data_out, dut.r_ptr_r);
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_fill_drain();
        w_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            data_in = 8'(i);
            tick();
            total++;
            if (fifo_full !== (i == 16) || fifo_empty !== 1'b0) begin
                bad++;
                $display("FAIL fill_flags n=%0d full=%b empty=%b",
                         i, fifo_full, fifo_empty);
            end
        end
        data_in = 8'hAA;
        tick();
        total++;
        if (dut.w_ptr_r !== 5'd16 || fifo_full !== 1'b1) begin
            bad++;
            $display("FAIL overflow wptr=%0d full=%b want 16/1",
                     dut.w_ptr_r, fifo_full);
        end
        w_en = 1'b0;
        r_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++;
            if (data_out !== 8'(i) || data_out !== exp_dout) begin
                bad++;
                $display("FAIL drain n=%0d got=%h want=%h",
                         i, data_out, 8'(i));
            end
            total++;
            if (fifo_full !== 1'b0 || fifo_empty !== (i == 16)) begin
                bad++;
                $display("FAIL drain_flags n=%0d full=%b empty=%b",
                         i, fifo_full, fifo_empty);
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] hist [0:39];
        logic [4:0] occ;
        w_en = 1'b1;
        r_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            hist[k] = 8'($urandom);
            data_in = hist[k];
            tick();
            occ = dut.w_ptr_r - dut.r_ptr_r;
            total++;
            if (occ !== 5'd1 || fifo_empty !== 1'b0 || fifo_full !== 1'b0) begin
                bad++;
                $display("FAIL b2b_occ k=%0d occ=%0d empty=%b full=%b",
                         k, occ, fifo_empty, fifo_full);
            end
            if (k > 0) begin
                total++;
                if (data_out !== hist[k-1] || data_out !== exp_dout) begin
                    bad++;
                    $display("FAIL b2b_data k=%0d got=%h want=%h",
                             k, data_out, hist[k-1]);
                end
            end
        end
        w_en = 1'b0;
        tick();
        total++;
        if (data_out !== hist[39] || fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL b2b_tail got=%h empty=%b want=%h/1",
                     data_out, fifo_empty, hist[39]);
        end
        r_en = 1'b0;
    endtask

    task automatic test_full_rw();
        w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'h40 + 8'(i);
            tick();
        end
        total++;
        if (fifo_full !== 1'b1) begin
            bad++;
            $display("FAIL full_rw_fill got=%b want=1", fifo_full);
        end
        r_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 8'h80 + 8'(i);
            tick();
            total++;
            if (data_out !== exp_dout) begin
                bad++;
                $display("FAIL full_rw_data c=%0d got=%h want=%h",
                         i, data_out, exp_dout);
            end
            total++;
            if (fifo_full !== (q.size() == 16)) begin
                bad++;
                $display("FAIL full_rw_flag c=%0d got=%b want=%b",
                         i, fifo_full, q.size() == 16);
            end
        end
        w_en = 1'b0;
        while (q.size() != 0) begin
            tick();
            total++;
            if (data_out !== exp_dout) begin
                bad++;
                $display("FAIL full_rw_drain got=%h want=%h",
                         data_out, exp_dout);
            end
        end
        total++;
        if (fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL full_rw_empty got=%b want=1", fifo_empty);
        end
        r_en = 1'b0;
    endtask

    task automatic test_midreset();
        w_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = 8'h10 + 8'(i);
            tick();
        end
        w_en = 1'b0;
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        resetn_i = 1'b0;
        w_en = 1'b1;
        data_in = 8'hEE;
        tick();
        resetn_i = 1'b1;
        w_en = 1'b0;
        r_en = 1'b0;
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
            data_out !== 8'h00) begin
            bad++;
            $display("FAIL midreset empty=%b full=%b dout=%h want 1/0/00",
                     fifo_empty, fifo_full, data_out);
        end
        total++;
        if (dut.w_ptr_r !== 5'd0 || dut.r_ptr_r !== 5'd0) begin
            bad++;
            $display("FAIL midreset_ptr w=%0d r=%0d want 0/0",
                     dut.w_ptr_r, dut.r_ptr_r);
        end
        w_en = 1'b1;
        data_in = 8'h5C;
        tick();
        w_en = 1'b0;
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        total++;
        if (data_out !== 8'h5C || fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL midreset_rw got=%h empty=%b want=5c/1",
                     data_out, fifo_empty);
        end
    endtask

    task automatic test_random();
        int wp;
        for (int c = 0; c < 2000; c++) begin
            wp = ((c / 250) % 2 == 0) ? 70 : 30;
            w_en = ($urandom_range(99) < wp);
            r_en = ($urandom_range(99) < 100 - wp);
            data_in = 8'($urandom);
            tick();
            total++;
            if (data_out !== exp_dout) begin
                bad++;
                $display("FAIL rand_data c=%0d got=%h want=%h",
                         c, data_out, exp_dout);
            end
            total++;
            if (fifo_empty !== (q.size() == 0) ||
                fifo_full !== (q.size() == 16)) begin
                bad++;
                $display("FAIL rand_flags c=%0d e=%b f=%b occ=%0d",
                         c, fifo_empty, fifo_full, q.size());
            end
        end
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_rw();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
